ifu_axi_rd_bridge: RTL and testbench

- Instruction-side read bridge between the fetch stage's simple request/data handshake (rx_* ports) and an AXI4 read channel pair (AR/R).
- Accepts one fetch address at a time, issues a single-beat AXI read, and holds the returned 64-bit beat until fetch takes it.
- Signals bus errors and timeouts back to fetch.
- Sits directly upstream of IF; fetch owns PC selection and jump discard.

---
 rtl/ifu_axi_rd_bridge.sv | 168 ++++++++++++++++
 tb/tb_ifu_axi_rd_bridge.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_axi_rd_bridge.sv
// Fetch-side single-beat AXI4 read bridge: one outstanding request, beat held until fetch takes it.
// Reports bus errors, timeouts and misaligned requests through rx_resp_err.
module ifu_axi_rd_bridge #(
  parameter logic [3:0] AXI_ID  = 4'h0,
  parameter int         TIMEOUT = 1023,
  parameter int         CNT_W   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_r_valid_i,
  output logic        rx_r_ready_o,
  input  logic [63:0] rx_r_addr_i,
  input  logic [7:0]  rx_r_size_i,
  output logic [63:0] rx_data_read_o,
  output logic        rx_data_valid,
  input  logic        rx_data_ready,
  output logic        rx_resp_err,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [63:0] axi_araddr,
  output logic [2:0]  axi_arsize,
  output logic [7:0]  axi_arlen,
  output logic [1:0]  axi_arburst,
  output logic [3:0]  axi_arid,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [63:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,
  input  logic [3:0]  axi_rid
);

  // state | meaning
  // IDLE  | waiting for a fetch address
  // ADDR  | AR offered (or misaligned request being turned into an error completion)
  // RDATA | waiting for the R beat, timeout counter running
  // HOLD  | completion presented to fetch until rx_data_ready
  typedef enum logic [1:0] {IDLE, ADDR, RDATA, HOLD} state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [63:0]       araddr_q, araddr_d;
  logic [2:0]        arsize_q, arsize_d;
  logic              misalign_q, misalign_d;
  logic [63:0]       data_q, data_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              sink_q, sink_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        req_size;
  logic [2:0]        low_mask;
  logic              timed_out;

  always_comb begin
    case (rx_r_size_i)
      8'h01:   req_size = 3'd0;
      8'h03:   req_size = 3'd1;
      8'h0F:   req_size = 3'd2;
      default: req_size = 3'd3;
    endcase
    case (req_size)
      3'd0:    low_mask = 3'b000;
      3'd1:    low_mask = 3'b001;
      3'd2:    low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
  end

  assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    arsize_d   = arsize_q;
    misalign_d = misalign_q;
    data_d     = data_q;
    err_d      = err_q;
    valid_d    = valid_q;
    sink_d     = sink_q;
    cnt_d      = cnt_q;

    // A stale beat from a timed-out read is swallowed wherever it shows up.
    if (sink_q && axi_rvalid) sink_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_r_valid_i) begin
          araddr_d   = {rx_r_addr_i[63:3], rx_r_addr_i[2:0] & ~low_mask};
          arsize_d   = req_size;
          misalign_d = |(rx_r_addr_i[2:0] & low_mask);
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (misalign_q) begin
          data_d     = '0;
          err_d      = 1'b1;
          valid_d    = 1'b1;
          misalign_d = 1'b0;
          state_d    = HOLD;
        end else if (axi_arready) begin
          cnt_d   = '0;
          state_d = RDATA;
        end
      end
      RDATA: begin
        cnt_d = cnt_q + 1'b1;
        if (axi_rvalid && !sink_q) begin
          data_d  = axi_rdata;
          err_d   = (axi_rresp != 2'b00) || !axi_rlast || (axi_rid != AXI_ID);
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (timed_out) begin
          data_d  = '0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          sink_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rx_data_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      araddr_q   <= '0;
      arsize_q   <= '0;
      misalign_q <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      sink_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      arsize_q   <= arsize_d;
      misalign_q <= misalign_d;
      data_q     <= data_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      sink_q     <= sink_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rx_r_ready_o   = (state_q == IDLE);
  assign rx_data_read_o = data_q;
  assign rx_data_valid  = valid_q;
  assign rx_resp_err    = err_q;
  assign axi_arvalid    = (state_q == ADDR) && !misalign_q;
  assign axi_araddr     = araddr_q;
  assign axi_arsize     = arsize_q;
  assign axi_arlen      = 8'h00;
  assign axi_arburst    = 2'b01;
  assign axi_arid       = AXI_ID;
  assign axi_rready     = (state_q == RDATA) || sink_q;

endmodule

// File: tb/tb_ifu_axi_rd_bridge.sv
// Self-checking bench for ifu_axi_rd_bridge: vector table, random reads against a
// reference model, and hand sequences for timeout, late beat and async reset.
module tb_ifu_axi_rd_bridge;

  localparam int TO = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_r_valid_i, rx_r_ready_o, rx_data_valid, rx_data_ready, rx_resp_err;
  logic [63:0] rx_r_addr_i, rx_data_read_o;
  logic [7:0]  rx_r_size_i;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
  logic [63:0] axi_araddr, axi_rdata;
  logic [2:0]  axi_arsize;
  logic [7:0]  axi_arlen;
  logic [1:0]  axi_arburst, axi_rresp;
  logic [3:0]  axi_arid, axi_rid;

  always #5 clk = ~clk;

  ifu_axi_rd_bridge #(.AXI_ID(4'h0), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_r_valid_i(rx_r_valid_i), .rx_r_ready_o(rx_r_ready_o),
    .rx_r_addr_i(rx_r_addr_i), .rx_r_size_i(rx_r_size_i),
    .rx_data_read_o(rx_data_read_o), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .rx_resp_err(rx_resp_err),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arsize(axi_arsize), .axi_arlen(axi_arlen), .axi_arburst(axi_arburst),
    .axi_arid(axi_arid), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  size;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    int          ar_wait;
    int          r_wait;
    int          d_wait;
    logic        mis;
    logic [63:0] exp_araddr;
    logic [2:0]  exp_arsize;
    logic        exp_err;
    logic [63:0] exp_data;
    int          exp_lat;
  } vec_t;

  // Reference: size mask -> transfer bytes, alignment by modulo, latency by handshake count.
  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    int unsigned bytes;
    case (v.size)
      8'h01:   e.exp_arsize = 3'd0;
      8'h03:   e.exp_arsize = 3'd1;
      8'h0F:   e.exp_arsize = 3'd2;
      default: e.exp_arsize = 3'd3;
    endcase
    bytes        = 1 << e.exp_arsize;
    e.mis        = (v.addr % bytes) != 0;
    e.exp_araddr = v.addr - (v.addr % bytes);
    if (e.mis) begin
      e.exp_err  = 1'b1;
      e.exp_data = '0;
      e.exp_lat  = 2;
    end else if (v.r_wait >= NEVER) begin
      e.exp_err  = 1'b1;
      e.exp_data = '0;
      e.exp_lat  = 2 + v.ar_wait + TO;
    end else begin
      e.exp_err  = (v.rresp != 2'b00) || !v.rlast || (v.rid != 4'h0);
      e.exp_data = v.rdata;
      e.exp_lat  = 3 + v.ar_wait + v.r_wait;
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [63:0] addr, input logic [7:0] size,
                              input logic [63:0] rdata, input logic [1:0] rresp,
                              input logic rlast, input logic [3:0] rid,
                              input int aw, input int rw, input int dw);
    vec_t v;
    v.addr = addr; v.size = size; v.rdata = rdata; v.rresp = rresp;
    v.rlast = rlast; v.rid = rid; v.ar_wait = aw; v.r_wait = rw; v.d_wait = dw;
    v.mis = 1'b0; v.exp_araddr = '0; v.exp_arsize = '0; v.exp_err = 1'b0;
    v.exp_data = '0; v.exp_lat = 0;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    logic [63:0] got_data = '0, seen_araddr = '0;
    logic [2:0]  seen_arsize = '0;
    logic        got_err = 1'b0;
    int lat = -1, ar_hs = 0, r_hs = 0, ar_cnt = 0, r_cnt = 0, d_cnt = 0;
    bit stable = 1, leak = 0, r_phase = 0, r_done = 0, seen_ar = 0, seen_d = 0, done = 0;
    int exp_hs;
    @(negedge clk);
    check({tag, " ready_idle"}, 64'(rx_r_ready_o), 64'd1);
    rx_r_valid_i = 1'b1;
    rx_r_addr_i  = v.addr;
    rx_r_size_i  = v.size;
    @(negedge clk);
    rx_r_valid_i = 1'b0;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      if (rx_r_ready_o) leak = 1;
      axi_arready = 1'b0;
      if (axi_arvalid) begin
        if (!seen_ar) begin
          seen_ar = 1; seen_araddr = axi_araddr; seen_arsize = axi_arsize;
        end else if (axi_araddr !== seen_araddr || axi_arsize !== seen_arsize) stable = 0;
        if (ar_cnt >= v.ar_wait) begin axi_arready = 1'b1; ar_hs++; end
        ar_cnt++;
      end
      axi_rvalid = 1'b0;
      if (r_phase && !r_done) begin
        if (r_cnt >= v.r_wait) begin
          axi_rvalid = 1'b1; axi_rdata = v.rdata; axi_rresp = v.rresp;
          axi_rlast = v.rlast; axi_rid = v.rid;
          if (axi_rready) begin r_hs++; r_done = 1; end
        end
        r_cnt++;
      end
      if (axi_arready) r_phase = 1;
      rx_data_ready = 1'b0;
      if (rx_data_valid) begin
        if (!seen_d) begin
          seen_d = 1; got_data = rx_data_read_o; got_err = rx_resp_err; lat = cyc;
        end else if (rx_data_read_o !== got_data || rx_resp_err !== got_err) stable = 0;
        if (d_cnt >= v.d_wait) begin rx_data_ready = 1'b1; done = 1; end
        d_cnt++;
      end
      @(negedge clk);
    end
    rx_data_ready = 1'b0; axi_arready = 1'b0; axi_rvalid = 1'b0;
    exp_hs = (v.mis || v.r_wait >= NEVER) ? 0 : 1;
    check({tag, " completed"}, 64'(done), 64'd1);
    check({tag, " data"}, got_data, v.exp_data);
    check({tag, " err"}, 64'(got_err), 64'(v.exp_err));
    check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, " ar_handshakes"}, 64'(ar_hs), 64'(v.mis ? 0 : 1));
    check({tag, " r_handshakes"}, 64'(r_hs), 64'(exp_hs));
    if (!v.mis) begin
      check({tag, " araddr"}, seen_araddr, v.exp_araddr);
      check({tag, " arsize"}, 64'(seen_arsize), 64'(v.exp_arsize));
    end
    check({tag, " stable"}, 64'(stable), 64'd1);
    check({tag, " no_ready_leak"}, 64'(leak), 64'd0);
    check({tag, " valid_dropped"}, 64'(rx_data_valid), 64'd0);
    check({tag, " err_held"}, 64'(rx_resp_err), 64'(v.exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " arvalid"}, 64'(axi_arvalid), 64'd0);
    check({tag, " rready"}, 64'(axi_rready), 64'd0);
    check({tag, " data_valid"}, 64'(rx_data_valid), 64'd0);
    check({tag, " resp_err"}, 64'(rx_resp_err), 64'd0);
    check({tag, " data"}, rx_data_read_o, 64'd0);
    check({tag, " araddr"}, axi_araddr, 64'd0);
    check({tag, " rx_ready"}, 64'(rx_r_ready_o), 64'd1);
  endtask

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t v;
    logic [7:0] sizes[5];
    rst_n = 1'b0;
    rx_r_valid_i = 0; rx_r_addr_i = '0; rx_r_size_i = '0; rx_data_ready = 0;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 0; axi_rid = '0;

    // Hand-derived expectations for the directed rows.
    tbl[0] = mk(64'h8000_0004, 8'h0F, 64'h0000_0013_0000_0297, 2'b00, 1, 4'h0, 0, 0, 0);
    tbl[0].exp_araddr = 64'h8000_0004; tbl[0].exp_arsize = 3'd2; tbl[0].exp_err = 0;
    tbl[0].exp_data = 64'h0000_0013_0000_0297; tbl[0].exp_lat = 3;
    tbl[1] = mk(64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 2'b00, 1, 4'h0, 5, 0, 3);
    tbl[1].exp_araddr = 64'h8000_0010; tbl[1].exp_arsize = 3'd3; tbl[1].exp_err = 0;
    tbl[1].exp_data = 64'h1122_3344_5566_7788; tbl[1].exp_lat = 8;
    tbl[2] = mk(64'h8000_0020, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 1, 4'h0, 0, 0, 0);
    tbl[2].exp_araddr = 64'h8000_0020; tbl[2].exp_arsize = 3'd3; tbl[2].exp_err = 1;
    tbl[2].exp_data = 64'hDEAD_BEEF_CAFE_F00D; tbl[2].exp_lat = 3;
    tbl[3] = mk(64'h8000_002A, 8'h03, 64'h0123_4567_89AB_CDEF, 2'b00, 1, 4'h0, 0, 2, 1);
    tbl[3].exp_araddr = 64'h8000_002A; tbl[3].exp_arsize = 3'd1; tbl[3].exp_err = 0;
    tbl[3].exp_data = 64'h0123_4567_89AB_CDEF; tbl[3].exp_lat = 5;
    tbl[4] = mk(64'h8000_0002, 8'h0F, 64'h5555_5555_5555_5555, 2'b00, 1, 4'h0, 0, 0, 0);
    tbl[4].mis = 1; tbl[4].exp_arsize = 3'd2; tbl[4].exp_err = 1;
    tbl[4].exp_data = 64'h0; tbl[4].exp_lat = 2;
    tbl[5] = mk(64'h8000_0008, 8'h07, 64'hA5A5_0000_FFFF_1234, 2'b00, 1, 4'h0, 0, 1, 0);
    tbl[5].exp_araddr = 64'h8000_0008; tbl[5].exp_arsize = 3'd3; tbl[5].exp_err = 0;
    tbl[5].exp_data = 64'hA5A5_0000_FFFF_1234; tbl[5].exp_lat = 4;
    tbl[6] = mk(64'h8000_0030, 8'hFF, 64'h0000_0000_0000_00AA, 2'b00, 0, 4'h0, 1, 0, 0);
    tbl[6].exp_araddr = 64'h8000_0030; tbl[6].exp_arsize = 3'd3; tbl[6].exp_err = 1;
    tbl[6].exp_data = 64'h0000_0000_0000_00AA; tbl[6].exp_lat = 4;
    tbl[7] = mk(64'h8000_0038, 8'hFF, 64'h0000_0000_0000_00BB, 2'b00, 1, 4'h3, 0, 0, 0);
    tbl[7].exp_araddr = 64'h8000_0038; tbl[7].exp_arsize = 3'd3; tbl[7].exp_err = 1;
    tbl[7].exp_data = 64'h0000_0000_0000_00BB; tbl[7].exp_lat = 3;
    tbl[8] = mk(64'h8000_0003, 8'h01, 64'h0000_0000_0000_00CC, 2'b00, 1, 4'h0, 0, 0, 0);
    tbl[8].exp_araddr = 64'h8000_0003; tbl[8].exp_arsize = 3'd0; tbl[8].exp_err = 0;
    tbl[8].exp_data = 64'h0000_0000_0000_00CC; tbl[8].exp_lat = 3;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset rx_ready", 64'(rx_r_ready_o), 64'd1);
    check("arlen", 64'(axi_arlen), 64'd0);
    check("arburst", 64'(axi_arburst), 64'd1);
    check("arid", 64'(axi_arid), 64'd0);

    foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Timeout then a late stale beat, which must be sunk and never forwarded.
    v = model(mk(64'h8000_0100, 8'hFF, 64'h0, 2'b00, 1, 4'h0, 0, NEVER, 0));
    run_txn(v, "timeout");
    @(negedge clk);
    check("late rready_sink", 64'(axi_rready), 64'd1);
    axi_rvalid = 1'b1; axi_rdata = 64'hBAD0_BAD0_BAD0_BAD0; axi_rresp = 2'b00;
    axi_rlast = 1'b1; axi_rid = 4'h0;
    @(negedge clk);
    axi_rvalid = 1'b0;
    check("late rready_dropped", 64'(axi_rready), 64'd0);
    check("late not_forwarded", 64'(rx_data_valid), 64'd0);
    check("late data_untouched", rx_data_read_o, 64'd0);
    run_txn(model(mk(64'h8000_0108, 8'hFF, 64'h7777_6666_5555_4444, 2'b00, 1, 4'h0, 0, 0, 0)),
            "after_timeout");

    // Async reset while in ADDR.
    @(negedge clk);
    rx_r_valid_i = 1'b1; rx_r_addr_i = 64'h8000_0040; rx_r_size_i = 8'hFF;
    @(negedge clk);
    rx_r_valid_i = 1'b0;
    check("rst_addr arvalid_before", 64'(axi_arvalid), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_addr");
    @(negedge clk); rst_n = 1'b1;

    // Async reset while in RDATA.
    @(negedge clk);
    rx_r_valid_i = 1'b1; rx_r_addr_i = 64'h8000_0048; rx_r_size_i = 8'hFF;
    @(negedge clk);
    rx_r_valid_i = 1'b0; axi_arready = 1'b1;
    @(negedge clk);
    axi_arready = 1'b0;
    check("rst_rdata rready_before", 64'(axi_rready), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_rdata");
    @(negedge clk); rst_n = 1'b1;
    run_txn(model(mk(64'h8000_0000, 8'hFF, 64'h0000_0000_1234_5678, 2'b00, 1, 4'h0, 0, 0, 0)),
            "after_reset");

    // Randomized reads against the reference model.
    sizes[0] = 8'h01; sizes[1] = 8'h03; sizes[2] = 8'h0F; sizes[3] = 8'hFF; sizes[4] = 8'h00;
    for (int n = 0; n < 24; n++) begin
      logic [7:0]  sz;
      logic [63:0] a;
      int sel;
      sel = $urandom_range(0, 4);
      sz = (sel == 4) ? 8'($urandom) : sizes[sel];
      a  = 64'h8000_0000 + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) a[2:0] = 3'b000;
      v = mk(a, sz, {$urandom, $urandom},
             ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
             ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0,
             $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2));
      run_txn(model(v), $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
